cmp_pipe: RTL and testbench

- Parametrised, pipelined magnitude comparator.
- Successor to the board-level 4-bit signed/unsigned switch comparator.
- Accepts WIDTH-bit operand pairs over a valid/ready handshake. Each pair carries a per-transaction signed/unsigned mode.
- Produces registered eq/gt/lt flags plus sign and magnitude outputs for the hex display drivers.
- Keeps saturating statistics counters of comparison outcomes for LED/HEX readout.

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/sat_counter.sv | 27 ++
 rtl/cmp_pipe.sv | 171 +++++++++++++++++
 tb/tb_cmp_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the cmp_pipe comparator: operand mode encoding and
// the magnitude helper used by the display outputs.
package cmp_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  // Widest operand abs_mag can handle; callers extend into this and truncate back.
  localparam int unsigned MAG_MAX_W = 64;

  // Caller passes the operand already sign-/zero-extended to MAG_MAX_W and keeps
  // the low WIDTH bits of the result; for the most-negative value this yields
  // 2^(WIDTH-1), read as unsigned.
  function automatic logic [MAG_MAX_W-1:0] abs_mag(
    input logic [MAG_MAX_W-1:0] value,
    input mode_e                signed_mode
  );
    logic [MAG_MAX_W-1:0] w_res;
    w_res = value;
    if ((signed_mode == MODE_SIGNED) && value[MAG_MAX_W-1]) begin
      w_res = ~value + MAG_MAX_W'(1);
    end
    return w_res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
  import cmp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, stick at all-ones, zero on reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined signed/unsigned magnitude comparator with valid/ready
// handshake and saturating outcome counters.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             x_neg,
  output logic             y_neg,
  output logic [WIDTH-1:0] x_mag,
  output logic [WIDTH-1:0] y_mag,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt
);

  // S1: raw operands
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_y;
  mode_e            r_s1_mode;

  // S2: registered result
  logic             r_s2_valid;
  logic             r_s2_eq;
  logic             r_s2_gt;
  logic             r_s2_lt;
  logic             r_s2_x_neg;
  logic             r_s2_y_neg;
  logic [WIDTH-1:0] r_s2_x_mag;
  logic [WIDTH-1:0] r_s2_y_mag;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_s1_load;
  logic w_s2_load;
  logic w_out_hs;

  logic signed [WIDTH:0] w_x_ext;
  logic signed [WIDTH:0] w_y_ext;
  logic                  w_eq;
  logic                  w_gt;
  logic                  w_lt;
  logic                  w_x_neg;
  logic                  w_y_neg;
  logic [WIDTH-1:0]      w_x_mag;
  logic [WIDTH-1:0]      w_y_mag;

  // An empty stage always loads, so ready depends only on valids and out_ready.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_s1_load = in_valid && w_s1_adv;
  assign w_s2_load = r_s1_valid && w_s2_adv;
  assign w_out_hs  = r_s2_valid && out_ready;

  // S1 register: capture operands and mode on input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_mode  <= MODE_UNSIGNED;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r_s1_x    <= in_x;
        r_s1_y    <= in_y;
        r_s1_mode <= mode_e'(in_signed);
      end
    end
  end

  // Compare and magnitude logic between S1 and S2 on one-bit-extended operands.
  always_comb begin
    w_x_ext = '0;
    w_y_ext = '0;
    if (r_s1_mode == MODE_SIGNED) begin
      w_x_ext = {r_s1_x[WIDTH-1], r_s1_x};
      w_y_ext = {r_s1_y[WIDTH-1], r_s1_y};
    end else begin
      w_x_ext = {1'b0, r_s1_x};
      w_y_ext = {1'b0, r_s1_y};
    end
    w_eq    = (w_x_ext == w_y_ext);
    w_gt    = (w_x_ext > w_y_ext);
    w_lt    = !w_eq && !w_gt;
    w_x_neg = (r_s1_mode == MODE_SIGNED) && r_s1_x[WIDTH-1];
    w_y_neg = (r_s1_mode == MODE_SIGNED) && r_s1_y[WIDTH-1];
    // Signed cast of the extended operand sign-extends into the helper width.
    w_x_mag = WIDTH'(abs_mag(MAG_MAX_W'(w_x_ext), r_s1_mode));
    w_y_mag = WIDTH'(abs_mag(MAG_MAX_W'(w_y_ext), r_s1_mode));
  end

  // S2 register: result only updates with real data, so flags hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_eq    <= 1'b0;
      r_s2_gt    <= 1'b0;
      r_s2_lt    <= 1'b0;
      r_s2_x_neg <= 1'b0;
      r_s2_y_neg <= 1'b0;
      r_s2_x_mag <= '0;
      r_s2_y_mag <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_s2_eq    <= w_eq;
        r_s2_gt    <= w_gt;
        r_s2_lt    <= w_lt;
        r_s2_x_neg <= w_x_neg;
        r_s2_y_neg <= w_y_neg;
        r_s2_x_mag <= w_x_mag;
        r_s2_y_mag <= w_y_mag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign eq        = r_s2_eq;
  assign gt        = r_s2_gt;
  assign lt        = r_s2_lt;
  assign x_neg     = r_s2_x_neg;
  assign y_neg     = r_s2_y_neg;
  assign x_mag     = r_s2_x_mag;
  assign y_mag     = r_s2_y_mag;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_eq (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (w_out_hs && r_s2_eq),
    .count (cnt_eq)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_gt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (w_out_hs && r_s2_gt),
    .count (cnt_gt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_lt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (w_out_hs && r_s2_lt),
    .count (cnt_lt)
  );

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe (WIDTH=4, CNT_W=2).
module tb_cmp_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       in_signed;
  logic       out_valid;
  logic       out_ready;
  logic       eq, gt, lt, x_neg, y_neg;
  logic [3:0] x_mag, y_mag;
  logic       stat_clr;
  logic [1:0] cnt_eq, cnt_gt, cnt_lt;

  int checks = 0;
  int errors = 0;

  // observed result word {eq,gt,lt,x_neg,y_neg,x_mag,y_mag}
  logic [12:0] obs;
  assign obs = {eq, gt, lt, x_neg, y_neg, x_mag, y_mag};

  // stimulus word {signed, x, y} and expected result words
  logic [8:0]  sg_in  [0:1] = '{9'b1_1010_0011, 9'b1_1000_1000};
  logic [12:0] sg_exp [0:1] = '{{3'b001, 2'b10, 4'h6, 4'h3}, {3'b100, 2'b11, 4'h8, 4'h8}};

  logic [8:0]  bb_in  [0:7] = '{9'b0_0000_0000, 9'b0_1111_0001, 9'b1_1111_0001, 9'b1_0111_1000,
                                9'b0_0111_1000, 9'b1_1100_1101, 9'b0_0101_0101, 9'b1_1000_1111};
  logic [12:0] bb_exp [0:7] = '{{3'b100, 2'b00, 4'h0, 4'h0}, {3'b010, 2'b00, 4'hF, 4'h1},
                                {3'b001, 2'b10, 4'h1, 4'h1}, {3'b010, 2'b01, 4'h7, 4'h8},
                                {3'b001, 2'b00, 4'h7, 4'h8}, {3'b001, 2'b11, 4'h4, 4'h3},
                                {3'b100, 2'b00, 4'h5, 4'h5}, {3'b001, 2'b11, 4'h8, 4'h1}};

  logic [8:0]  bp_in  [0:2] = '{9'b0_0010_1001, 9'b0_1001_0010, 9'b1_1110_1110};
  logic [12:0] bp_exp [0:2] = '{{3'b001, 2'b00, 4'h2, 4'h9}, {3'b010, 2'b00, 4'h9, 4'h2},
                                {3'b100, 2'b11, 4'h2, 4'h2}};
  logic        bp_rdy [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [8:0]  sc_in  [0:6] = '{9'b0_0011_0011, 9'b0_0011_0011, 9'b0_0011_0011, 9'b0_0011_0011,
                                9'b0_0011_0011, 9'b0_0100_0001, 9'b0_0001_0100};

  cmp_pipe #(.WIDTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .x_neg     (x_neg),
    .y_neg     (y_neg),
    .x_mag     (x_mag),
    .y_mag     (y_mag),
    .stat_clr  (stat_clr),
    .cnt_eq    (cnt_eq),
    .cnt_gt    (cnt_gt),
    .cnt_lt    (cnt_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [8:0] w);
    in_valid  = v;
    in_signed = w[8];
    in_x      = w[7:4];
    in_y      = w[3:0];
  endtask

  // leaves the bench 1 time unit after a rising edge
  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    in_x = '0; in_y = '0; in_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, obs} !== 14'b0) begin
      errors++; $display("FAIL reset_outputs got %b want %b", {out_valid, obs}, 14'b0);
    end
    checks++;
    if ({cnt_eq, cnt_gt, cnt_lt} !== 6'b0) begin
      errors++; $display("FAIL reset_counters got %b want %b", {cnt_eq, cnt_gt, cnt_lt}, 6'b0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    drive(1'b1, 9'b0_1010_0011);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL uns_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1 drive(1'b0, 9'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL uns_latency_early got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, obs} !== {1'b1, 3'b010, 2'b00, 4'hA, 4'h3}) begin
      errors++; $display("FAIL uns_result got %b want %b", {out_valid, obs}, {1'b1, 3'b010, 2'b00, 4'hA, 4'h3});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, cnt_eq, cnt_gt, cnt_lt} !== {1'b0, 2'd0, 2'd1, 2'd0}) begin
      errors++; $display("FAIL uns_count got %b want %b", {out_valid, cnt_eq, cnt_gt, cnt_lt}, {1'b0, 2'd0, 2'd1, 2'd0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, sg_in[i]);
      @(posedge clk); #1 drive(1'b0, 9'b0);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({out_valid, obs} !== {1'b1, sg_exp[i]}) begin
        errors++; $display("FAIL signed_result[%0d] got %b want %b", i, {out_valid, obs}, {1'b1, sg_exp[i]});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({cnt_eq, cnt_gt, cnt_lt} !== {2'd1, 2'd1, 2'd1}) begin
      errors++; $display("FAIL signed_counts got %b want %b", {cnt_eq, cnt_gt, cnt_lt}, {2'd1, 2'd1, 2'd1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int k;
    k = 0;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(1'b1, bb_in[cyc]);
      else         drive(1'b0, 9'b0);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready cyc %0d got %b want 1", cyc, in_ready);
      end
      checks++;
      if (out_valid !== ((cyc >= 2) && (cyc <= 9))) begin
        errors++; $display("FAIL b2b_out_valid cyc %0d got %b want %b", cyc, out_valid, ((cyc >= 2) && (cyc <= 9)));
      end
      if (out_valid === 1'b1 && k < 8) begin
        checks++;
        if (obs !== bb_exp[k]) begin
          errors++; $display("FAIL b2b_result[%0d] got %b want %b", k, obs, bb_exp[k]);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({cnt_eq, cnt_gt, cnt_lt} !== {2'd2, 2'd2, 2'd3}) begin
      errors++; $display("FAIL b2b_counts_sat got %b want %b", {cnt_eq, cnt_gt, cnt_lt}, {2'd2, 2'd2, 2'd3});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int idx;
    int k;
    logic acc;
    idx = 0; k = 0;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      out_ready = (it >= 5);
      if (idx < 3) drive(1'b1, bp_in[idx]);
      else         drive(1'b0, 9'b0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (it < 6) begin
        checks++;
        if (in_ready !== bp_rdy[it]) begin
          errors++; $display("FAIL bp_in_ready it %0d got %b want %b", it, in_ready, bp_rdy[it]);
        end
      end
      if (it >= 2 && it <= 4) begin
        checks++;
        if ({out_valid, obs} !== {1'b1, bp_exp[0]}) begin
          errors++; $display("FAIL bp_stall_stable it %0d got %b want %b", it, {out_valid, obs}, {1'b1, bp_exp[0]});
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (k >= 3) begin
          errors++; $display("FAIL bp_duplicate got %0d deliveries want 3", k + 1);
        end else if (obs !== bp_exp[k]) begin
          errors++; $display("FAIL bp_order[%0d] got %b want %b", k, obs, bp_exp[k]);
        end
        k++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++;
    if (k !== 3) begin
      errors++; $display("FAIL bp_delivered got %0d want 3", k);
    end
    @(negedge clk);
    checks++;
    if ({cnt_eq, cnt_gt, cnt_lt} !== {2'd1, 2'd1, 2'd1}) begin
      errors++; $display("FAIL bp_counts got %b want %b", {cnt_eq, cnt_gt, cnt_lt}, {2'd1, 2'd1, 2'd1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stat_clr;
    do_reset();
    for (int it = 0; it < 11; it++) begin
      if (it < 7) drive(1'b1, sc_in[it]);
      else        drive(1'b0, 9'b0);
      stat_clr = (it == 8);
      @(negedge clk);
      if (it == 7) begin
        checks++;
        if ({cnt_eq, cnt_gt} !== {2'd3, 2'd0}) begin
          errors++; $display("FAIL clr_eq_saturated got %b want %b", {cnt_eq, cnt_gt}, {2'd3, 2'd0});
        end
      end
      if (it == 8) begin
        checks++;
        if ({out_valid, obs, cnt_gt} !== {1'b1, 3'b001, 2'b00, 4'h1, 4'h4, 2'd1}) begin
          errors++; $display("FAIL clr_before got %b want %b", {out_valid, obs, cnt_gt}, {1'b1, 3'b001, 2'b00, 4'h1, 4'h4, 2'd1});
        end
      end
      if (it == 9 || it == 10) begin
        checks++;
        if ({cnt_eq, cnt_gt, cnt_lt} !== 6'b0) begin
          errors++; $display("FAIL clr_wins it %0d got %b want %b", it, {cnt_eq, cnt_gt, cnt_lt}, 6'b0);
        end
      end
      @(posedge clk); #1;
    end
    stat_clr = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, 9'b0_0101_0101);
    @(posedge clk); #1 drive(1'b1, 9'b0_0110_0101);
    @(posedge clk); #1 drive(1'b0, 9'b0);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      errors++; $display("FAIL rstmid_full got %b want %b", {in_ready, out_valid}, 2'b01);
    end
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, obs, cnt_eq, cnt_gt, cnt_lt} !== 20'b0) begin
      errors++; $display("FAIL rstmid_cleared got %b want %b", {out_valid, obs, cnt_eq, cnt_gt, cnt_lt}, 20'b0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, cnt_eq, cnt_gt, cnt_lt} !== 7'b0) begin
      errors++; $display("FAIL rstmid_s1_discarded got %b want %b", {out_valid, cnt_eq, cnt_gt, cnt_lt}, 7'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_stat_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
